// File: rtl/avalon_mx_pkg.sv
// Shared constants, return-event kind and width helper for the Avalon matrix decoder.
package avalon_mx_pkg;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_DECERR = 2'b11;
   localparam logic [31:0] DECERR_WORD = 32'hDEADBEEF;

   // Kind of read return seen by the tracker in the current cycle.
   typedef enum logic [1:0] {
      RET_NONE  = 2'd0,
      RET_SLAVE = 2'd1,
      RET_VIRT  = 2'd2
   } ret_kind_e;

   // Bits needed to hold values 0..value-1, never less than 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/avalon_mx_decoder_pipe_if.sv
// Bus bundle between one matrix master and its decoder; slave modport is the decoder view.
interface avalon_mx_decoder_pipe_if #(
   parameter int NUM_SLV = 3,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 512,
   parameter int ID_W    = 3,
   parameter int OUTST_W = 3
);
   // Handshake: a master access (RdEn_i|WrEn_i) is taken in the cycle WaitReq_o is low;
   // while WaitReq_o is high the master holds the access. RdValid_* qualify data for one cycle.
   logic [ADDR_W-1:0]       Addr_i;
   logic                    RdEn_i;
   logic                    WrEn_i;
   logic [NUM_SLV*DATA_W-1:0] RdData_i;
   logic [NUM_SLV-1:0]      RdValid_i;
   logic [NUM_SLV-1:0]      WaitReq_i;
   logic [NUM_SLV*ID_W-1:0] PortSel_i;
   logic [NUM_SLV-1:0]      Req_o;
   logic                    WaitReq_o;
   logic [DATA_W-1:0]       RdData_o;
   logic                    RdValid_o;
   logic [1:0]              RdResp_o;
   logic [OUTST_W-1:0]      Outst_o;
   logic                    ProtErr_o;

   modport slave (
      input  Addr_i, RdEn_i, WrEn_i, RdData_i, RdValid_i, WaitReq_i, PortSel_i,
      output Req_o, WaitReq_o, RdData_o, RdValid_o, RdResp_o, Outst_o, ProtErr_o
   );

   modport master (
      output Addr_i, RdEn_i, WrEn_i, RdData_i, RdValid_i, WaitReq_i, PortSel_i,
      input  Req_o, WaitReq_o, RdData_o, RdValid_o, RdResp_o, Outst_o, ProtErr_o
   );

endinterface

// File: rtl/avalon_mx_rd_tracker.sv
// Outstanding-read bookkeeping: count, owner slave, stall terms, return event, sticky protocol error.
module avalon_mx_rd_tracker
   import avalon_mx_pkg::*;
#(
   parameter int NUM_SLV   = 3,
   parameter int MAX_OUTST = 4,
   parameter int TGT_W     = 2,
   parameter int CNT_W     = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic [TGT_W-1:0]   tgt,
   input  logic               rd_accept,
   input  logic [NUM_SLV-1:0] rd_valid,
   output logic [CNT_W-1:0]   count,
   output logic [TGT_W-1:0]   owner,
   output logic               swstall,
   output logic               full,
   output ret_kind_e          ret_kind,
   output logic               prot_err
);

   logic               busy;
   logic               virt_pend;
   logic               ret;
   logic [NUM_SLV-1:0] owner_mask;

   assign busy    = (count != '0);
   assign swstall = rd_en & busy & (tgt != owner);
   assign full    = rd_en & (count == CNT_W'(MAX_OUTST));

   // Only the owner's RdValid is a legal return, and only while reads are in flight.
   always_comb begin
      owner_mask = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (busy && owner == TGT_W'(i)) owner_mask[i] = 1'b1;
      end
   end

   always_comb begin
      ret_kind = RET_NONE;
      if (virt_pend)                       ret_kind = RET_VIRT;
      else if ((rd_valid & owner_mask) != '0) ret_kind = RET_SLAVE;
   end

   assign ret = (ret_kind != RET_NONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         owner     <= '0;
         virt_pend <= 1'b0;
         prot_err  <= 1'b0;
      end else begin
         case ({rd_accept, ret})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (rd_accept) owner <= tgt;
         // The virtual error slave answers exactly one cycle after each accepted read.
         virt_pend <= rd_accept & (tgt == TGT_W'(NUM_SLV));
         prot_err  <= prot_err | ((rd_valid & ~owner_mask) != '0);
      end
   end

endmodule

// File: rtl/avalon_mx_decoder_pipe.sv
// Master-side matrix decoder: address decode, wait generation, pipelined-read return path.
// Build option AVALON_MX_DECERR_EN: unmapped reads return DEADBEEF data with DECODEERROR.
module avalon_mx_decoder_pipe
   import avalon_mx_pkg::*;
#(
   parameter int                 NUM_SLV   = 3,
   parameter int                 ADDR_W    = 64,
   parameter int                 DATA_W    = 512,
   parameter int                 SEL_LSB   = 9,
   parameter int                 SEL_W     = 2,
   parameter logic [NUM_SLV-1:0] PORT_EN   = {NUM_SLV{1'b1}},
   parameter int                 ID_W      = 3,
   parameter int                 MST_ID    = 0,
   parameter int                 MAX_OUTST = 4
) (
   input logic                    clk,
   input logic                    rst,
   avalon_mx_decoder_pipe_if.slave bus
);

   localparam int TGT_W = clog2(NUM_SLV + 1);
   localparam int CNT_W = clog2(MAX_OUTST + 1);

`ifdef AVALON_MX_DECERR_EN
   localparam logic [DATA_W-1:0] VIRT_DATA = {(DATA_W/32){DECERR_WORD}};
   localparam logic [1:0]        VIRT_RESP = RESP_DECERR;
`else
   localparam logic [DATA_W-1:0] VIRT_DATA = '0;
   localparam logic [1:0]        VIRT_RESP = RESP_OKAY;
`endif

   logic [SEL_W-1:0]   field;
   logic [NUM_SLV-1:0] hit;
   logic [NUM_SLV-1:0] req;
   logic [TGT_W-1:0]   tgt;
   logic [TGT_W-1:0]   owner;
   logic [CNT_W-1:0]   count;
   logic               access;
   logic               swstall;
   logic               full;
   logic               slv_wait;
   logic               wait_req;
   logic               rd_accept;
   logic               prot_err;
   ret_kind_e          ret_kind;
   logic [DATA_W-1:0]  owner_data;
   logic [DATA_W-1:0]  rd_data_q;
   logic               rd_valid_q;
   logic [1:0]         rd_resp_q;
   logic               unused_addr;

   assign field       = bus.Addr_i[SEL_LSB +: SEL_W];
   assign unused_addr = ^bus.Addr_i;
   assign access      = bus.RdEn_i | bus.WrEn_i;

   // A field value with no enabled slave selects the virtual error slave (index NUM_SLV).
   always_comb begin
      hit = '0;
      tgt = TGT_W'(NUM_SLV);
      for (int i = 0; i < NUM_SLV; i++) begin
         if ((32'(field) == i) && PORT_EN[i]) begin
            hit[i] = 1'b1;
            tgt    = TGT_W'(i);
         end
      end
   end

   always_comb begin
      req      = '0;
      slv_wait = 1'b0;
      for (int i = 0; i < NUM_SLV; i++) begin
         req[i]   = hit[i] & access & ~swstall & ~full;
         slv_wait = slv_wait | (req[i] & ((bus.PortSel_i[i*ID_W +: ID_W] != ID_W'(MST_ID))
                                          | bus.WaitReq_i[i]));
      end
   end

   assign wait_req  = swstall | full | slv_wait;
   assign rd_accept = bus.RdEn_i & ~wait_req;

   avalon_mx_rd_tracker #(
      .NUM_SLV   (NUM_SLV),
      .MAX_OUTST (MAX_OUTST),
      .TGT_W     (TGT_W),
      .CNT_W     (CNT_W)
   ) u_tracker (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (bus.RdEn_i),
      .tgt       (tgt),
      .rd_accept (rd_accept),
      .rd_valid  (bus.RdValid_i),
      .count     (count),
      .owner     (owner),
      .swstall   (swstall),
      .full      (full),
      .ret_kind  (ret_kind),
      .prot_err  (prot_err)
   );

   always_comb begin
      owner_data = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (owner == TGT_W'(i)) owner_data = bus.RdData_i[i*DATA_W +: DATA_W];
      end
   end

   // Data and response hold their last value between returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_resp_q  <= RESP_OKAY;
      end else begin
         rd_valid_q <= (ret_kind != RET_NONE);
         if (ret_kind == RET_SLAVE) begin
            rd_data_q <= owner_data;
            rd_resp_q <= RESP_OKAY;
         end else if (ret_kind == RET_VIRT) begin
            rd_data_q <= VIRT_DATA;
            rd_resp_q <= VIRT_RESP;
         end
      end
   end

   assign bus.Req_o     = req;
   assign bus.WaitReq_o = wait_req;
   assign bus.RdData_o  = rd_data_q;
   assign bus.RdValid_o = rd_valid_q;
   assign bus.RdResp_o  = rd_resp_q;
   assign bus.Outst_o   = count;
   assign bus.ProtErr_o = prot_err;

endmodule
